stage5_mem_stage: RTL and testbench
===================================

Name: stage5_mem_stage

Overview:
- Consumer end of the execute→mem pipeline interface in the 5-stage core.
- Latches the ex_mem_t bundle and performs load/store over the data bus with a busy handshake.
- Drives the fetch redirect: branch/jump target on brj_addr, or pc+4 on pc4 for fence_i/CSR flushes.
- Produces the registered mem→writeback bundle.

Parameters:
- MAX_WAIT, 255: dbus_busy cycles tolerated per access before abort; 0 disables the watchdog.

Ports:
- CLK  in  1  core clock
- RST  in  1  synchronous, active-high reset
- ex_valid  in  1  ex_mem_reg holds a live instruction
- ex_mem_reg  in  ex_mem_t  fields: pc, alu_result (addr/result), store_data, dren, dwen, ld_st_type (B/H/W, unsigned), rd, reg_wen, brj_taken, brj_target, ifence, csr_flush
- mem_ready  out  1  stage can accept ex_mem_reg this cycle; low = stall execute
- dbus_addr  out  32  word-aligned address
- dbus_wdata  out  32  store data, lane-replicated
- dbus_byte_en  out  4  byte lane enables
- dbus_ren  out  1  read request
- dbus_wen  out  1  write request
- dbus_busy  in  1  bus not done; data/ack valid in the first cycle it is low
- dbus_rdata  in  32  read data
- brj_addr  out  32  branch/jump redirect target
- pc4  out  32  flush redirect target
- redirect_brj  out  1  one-cycle pulse qualifying brj_addr
- redirect_pc4  out  1  one-cycle pulse qualifying pc4
- wb_valid  out  1  mem_wb bundle valid
- wb_rd  out  5  destination register
- wb_wen  out  1  register write enable
- wb_data  out  32  load result or ALU result
- misalign_fault  out  1  one-cycle pulse: misaligned access suppressed
- bus_timeout  out  1  one-cycle pulse: watchdog abort

Behaviour:
- Reset (sync, high): FSM=IDLE, wait counter=0, and every output driven 0 the following cycle. mem_ready=1 in IDLE.
- Reset during ACCESS: ren/wen drop after that edge; in-flight instruction discarded, no wb, no redirect.
- FSM states IDLE, ACCESS.
  - IDLE with ex_valid and no memory op: one-cycle pass-through. Next cycle wb_valid=1, wb_data=alu_result; redirect pulses in that same cycle.
  - IDLE with ex_valid and (dren|dwen), aligned: capture the bundle, go to ACCESS. ren/wen, addr, byte_en and wdata are registered; they assert the cycle after capture and are held stable until completion.
  - ACCESS, dbus_busy=0: complete. Load data sampled, request deasserted next edge, return to IDLE. wb_valid and any redirect pulse 1 cycle after completion.
  - ACCESS, dbus_busy=1: counter++. If MAX_WAIT≠0 and counter==MAX_WAIT: abort, bus_timeout pulse, wb_valid=1 with wb_wen=0, IDLE.
  - mem_ready=0 in ACCESS, except the completion cycle, where it is 1 so back-to-back accesses have one idle bus cycle.
- Minimum load-to-wb latency: 2 cycles (capture, access with busy=0 immediately).
- Alignment: H requires addr[0]=0; W requires addr[1:0]=0. Violation: no bus request, misalign_fault pulse, wb_valid=1, wb_wen=0, no redirect.
- Store lanes:
  - B: byte_en = 1<<addr[1:0], wdata = {4{byte}}.
  - H: byte_en = 0011 or 1100, wdata = {2{half}}.
  - W: 1111.
- Load extract: select by addr[1:0]; sign-extend unless the unsigned flag is set.
- dbus_addr = {alu_result[31:2], 2'b00}.
- Redirect priority: fault/timeout (none) > brj_taken (brj_addr=brj_target) > ifence|csr_flush (pc4=pc+4, mod 2^32; pc=FFFFFFFC → 00000000). At most one redirect pulse per instruction.
- wb_* registers hold the last value when wb_valid=0. wb_wen is gated by reg_wen and rd≠0.

Decomposition:
- stage5_types_pkg: ex_mem_t, mem_wb_t, ld_st_type enum, mem_fsm_t.
- rv32i_types_pkg: word_t.
- One sub-module, stage5_mem_lane_align: combinational byte_en/wdata generation and load extract/extend plus alignment check. FSM, watchdog and redirect logic stay in the top.

Test Plan:
- ALU op, alu_result=0x1234, rd=5 → next cycle wb_valid=1, wb_rd=5, wb_data=0x1234, dbus_ren=0.
- LB at addr 0x103 with busy 3 cycles, rdata=0x80FFFFFF → ren held 3 cycles plus completion, wb_data=0xFFFFFF80. Same with LBU → 0x00000080.
- SH at 0x202, store_data=0xABCD → dbus_addr=0x200, byte_en=1100, wdata=0xABCDABCD, wb_wen=0.
- LW at 0x101 → no bus request, misalign_fault pulse, wb_wen=0. JAL brj_target=0x400 → redirect_brj pulse, brj_addr=0x400. fence_i at pc=0x80 → redirect_pc4, pc4=0x84.
- MAX_WAIT=4, busy stuck high → bus_timeout after 4 wait cycles, ren drops, mem_ready=1 the next cycle.
- RST asserted mid-ACCESS → ren=0 and wb_valid=0 next cycle, no redirect; new load accepted right after reset release.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// Base RV32I types shared across the core.
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/stage5_types_pkg.sv
// Pipeline bundle types for the execute->mem->writeback interfaces of the 5-stage core,
// the load/store size encoding and the mem-stage FSM state type.
package stage5_types_pkg;

    import rv32i_types_pkg::word_t;

    // Bits [1:0] give the access size (B/H/W), bit 2 marks an unsigned load.
    typedef enum logic [2:0] {
        LsB  = 3'b000,
        LsH  = 3'b001,
        LsW  = 3'b010,
        LsBu = 3'b100,
        LsHu = 3'b101
    } ld_st_type_e;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StAccess = 1'b1
    } mem_fsm_t;

    typedef struct packed {
        word_t       pc;
        word_t       alu_result;
        word_t       store_data;
        logic        dren;
        logic        dwen;
        ld_st_type_e ld_st_type;
        logic [4:0]  rd;
        logic        reg_wen;
        logic        brj_taken;
        word_t       brj_target;
        logic        ifence;
        logic        csr_flush;
    } ex_mem_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wen;
        word_t      data;
    } mem_wb_t;

    localparam logic [1:0] SizeB = 2'b00;
    localparam logic [1:0] SizeH = 2'b01;
    localparam logic [1:0] SizeW = 2'b10;

    function automatic logic [1:0] ls_size(ld_st_type_e t);
        return t[1:0];
    endfunction

    function automatic logic ls_unsigned(ld_st_type_e t);
        return t[2];
    endfunction

endpackage

// File: rtl/stage5_mem_lane_align.sv
// Combinational data-bus lane logic for the mem stage.
//   addr        in  byte address of the access
//   ld_st_type  in  access size and load signedness
//   store_data  in  raw store operand
//   rdata       in  word read from the data bus
//   byte_en     out byte lane enables for the addressed lanes
//   wdata       out store data replicated across lanes
//   load_data   out selected and extended load result
//   misaligned  out access violates natural alignment for its size
module stage5_mem_lane_align
    import stage5_types_pkg::*;
(
    input  logic [31:0] addr,
    input  ld_st_type_e ld_st_type,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [1:0]  lane;
    logic        uns;
    logic [31:0] rshift;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        lane       = addr[1:0];
        uns        = ls_unsigned(ld_st_type);
        rshift     = rdata >> {lane, 3'b000};
        ld_byte    = rshift[7:0];
        ld_half    = addr[1] ? rdata[31:16] : rdata[15:0];
        byte_en    = 4'b1111;
        wdata      = store_data;
        load_data  = rdata;
        misaligned = 1'b0;
        case (ls_size(ld_st_type))
            SizeB: begin
                byte_en   = 4'b0001 << lane;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{ld_byte[7] & ~uns}}, ld_byte};
            end
            SizeH: begin
                misaligned = addr[0];
                byte_en    = addr[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                load_data  = {{16{ld_half[15] & ~uns}}, ld_half};
            end
            default: begin
                misaligned = |addr[1:0];
            end
        endcase
    end

endmodule

// File: rtl/stage5_mem_stage.sv
// Memory stage of the 5-stage core: consumes the execute->mem bundle, runs loads/stores
// over a busy-handshake data bus with a wait watchdog, raises fetch redirects and
// produces the registered writeback bundle.
//   CLK, RST            clock, synchronous active-high reset
//   ex_valid/ex_mem_reg incoming instruction bundle; mem_ready low stalls execute
//   dbus_*              registered data-bus request, dbus_busy/dbus_rdata response
//   brj_addr/pc4        redirect targets, qualified by redirect_brj/redirect_pc4 pulses
//   wb_*                registered writeback bundle
//   misalign_fault      pulse when a misaligned access is suppressed
//   bus_timeout         pulse when the watchdog aborts an access
module stage5_mem_stage
    import rv32i_types_pkg::*;
    import stage5_types_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ex_valid,
    input  ex_mem_t     ex_mem_reg,
    output logic        mem_ready,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_byte_en,
    output logic        dbus_ren,
    output logic        dbus_wen,
    input  logic        dbus_busy,
    input  logic [31:0] dbus_rdata,
    output logic [31:0] brj_addr,
    output logic [31:0] pc4,
    output logic        redirect_brj,
    output logic        redirect_pc4,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_wen,
    output logic [31:0] wb_data,
    output logic        misalign_fault,
    output logic        bus_timeout
);

    localparam int unsigned CntW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

    mem_fsm_t        state_q, state_d;
    ex_mem_t         inst_q, inst_d;
    logic            pend_q, pend_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ren_q, ren_d, wen_q, wen_d;
    word_t           addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    word_t           brj_addr_q, brj_addr_d, pc4_q, pc4_d;
    logic            redir_brj_q, redir_brj_d, redir_pc4_q, redir_pc4_d;
    mem_wb_t         wb_q, wb_d;
    logic            misalign_q, misalign_d, timeout_q, timeout_d;

    // An instruction accepted in a completion cycle is parked in inst_q (pend_q) and
    // processed in the following idle cycle so its writeback cannot collide.
    ex_mem_t src;
    logic    src_valid, src_is_mem;

    word_t       la_addr, la_wdata, la_load;
    ld_st_type_e la_type;
    logic [3:0]  la_be;
    logic        la_misaligned;

    logic    retire, ret_abort;
    ex_mem_t ret;
    word_t   ret_data;

    always_comb begin
        src        = pend_q ? inst_q : ex_mem_reg;
        src_valid  = pend_q | ex_valid;
        src_is_mem = src.dren | src.dwen;
        la_addr    = (state_q == StAccess) ? inst_q.alu_result : src.alu_result;
        la_type    = (state_q == StAccess) ? inst_q.ld_st_type : src.ld_st_type;
        mem_ready  = (state_q == StIdle) ? ~pend_q : ~dbus_busy;
    end

    stage5_mem_lane_align u_lane_align (
        .addr       (la_addr),
        .ld_st_type (la_type),
        .store_data (src.store_data),
        .rdata      (dbus_rdata),
        .byte_en    (la_be),
        .wdata      (la_wdata),
        .load_data  (la_load),
        .misaligned (la_misaligned)
    );

    always_comb begin
        state_d     = state_q;
        inst_d      = inst_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        ren_d       = ren_q;
        wen_d       = wen_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        brj_addr_d  = brj_addr_q;
        pc4_d       = pc4_q;
        redir_brj_d = 1'b0;
        redir_pc4_d = 1'b0;
        wb_d        = wb_q;
        wb_d.valid  = 1'b0;
        misalign_d  = 1'b0;
        timeout_d   = 1'b0;
        retire      = 1'b0;
        ret_abort   = 1'b0;
        ret         = inst_q;
        ret_data    = inst_q.alu_result;

        unique case (state_q)
            StIdle: begin
                if (src_valid) begin
                    pend_d = 1'b0;
                    if (src_is_mem && !la_misaligned) begin
                        state_d = StAccess;
                        inst_d  = src;
                        cnt_d   = '0;
                        ren_d   = src.dren;
                        wen_d   = src.dwen;
                        addr_d  = {src.alu_result[31:2], 2'b00};
                        be_d    = la_be;
                        wdata_d = la_wdata;
                    end else begin
                        // Non-memory op, or a misaligned access that never reaches the bus.
                        retire     = 1'b1;
                        ret        = src;
                        ret_data   = src.alu_result;
                        ret_abort  = src_is_mem;
                        misalign_d = src_is_mem;
                    end
                end
            end
            StAccess: begin
                if (!dbus_busy) begin
                    state_d  = StIdle;
                    ren_d    = 1'b0;
                    wen_d    = 1'b0;
                    retire   = 1'b1;
                    ret_data = inst_q.dren ? la_load : inst_q.alu_result;
                    if (ex_valid) begin
                        pend_d = 1'b1;
                        inst_d = ex_mem_reg;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (MAX_WAIT != 0 && cnt_d == MaxCnt) begin
                        state_d   = StIdle;
                        ren_d     = 1'b0;
                        wen_d     = 1'b0;
                        retire    = 1'b1;
                        ret_abort = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
            end
        endcase

        if (retire) begin
            wb_d.valid = 1'b1;
            wb_d.rd    = ret.rd;
            wb_d.wen   = ret.reg_wen && (ret.rd != 5'd0) && !ret_abort;
            wb_d.data  = ret_data;
            if (!ret_abort) begin
                if (ret.brj_taken) begin
                    redir_brj_d = 1'b1;
                    brj_addr_d  = ret.brj_target;
                end else if (ret.ifence || ret.csr_flush) begin
                    redir_pc4_d = 1'b1;
                    pc4_d       = ret.pc + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            inst_q      <= '0;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            brj_addr_q  <= '0;
            pc4_q       <= '0;
            redir_brj_q <= 1'b0;
            redir_pc4_q <= 1'b0;
            wb_q        <= '0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            inst_q      <= inst_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            ren_q       <= ren_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            brj_addr_q  <= brj_addr_d;
            pc4_q       <= pc4_d;
            redir_brj_q <= redir_brj_d;
            redir_pc4_q <= redir_pc4_d;
            wb_q        <= wb_d;
            misalign_q  <= misalign_d;
            timeout_q   <= timeout_d;
        end
    end

    assign dbus_addr      = addr_q;
    assign dbus_wdata     = wdata_q;
    assign dbus_byte_en   = be_q;
    assign dbus_ren       = ren_q;
    assign dbus_wen       = wen_q;
    assign brj_addr       = brj_addr_q;
    assign pc4            = pc4_q;
    assign redirect_brj   = redir_brj_q;
    assign redirect_pc4   = redir_pc4_q;
    assign wb_valid       = wb_q.valid;
    assign wb_rd          = wb_q.rd;
    assign wb_wen         = wb_q.wen;
    assign wb_data        = wb_q.data;
    assign misalign_fault = misalign_q;
    assign bus_timeout    = timeout_q;

endmodule

// File: tb/tb_stage5_mem_stage.sv
// Scoreboard bench for stage5_mem_stage: stimulus pushes expected writeback/redirect
// events into a queue, a negedge monitor pops and compares whenever wb_valid is high.
module tb_stage5_mem_stage;
    import rv32i_types_pkg::*;
    import stage5_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ex_valid = 1'b0;
    ex_mem_t     ex_mem_reg = '0;
    logic        mem_ready;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata = '0;
    logic [3:0]  dbus_byte_en;
    logic        dbus_ren, dbus_wen, dbus_busy = 1'b0;
    logic [31:0] brj_addr, pc4, wb_data;
    logic        redirect_brj, redirect_pc4, wb_valid, wb_wen, misalign_fault, bus_timeout;
    logic [4:0]  wb_rd;

    stage5_mem_stage #(.MAX_WAIT(4)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .ex_valid       (ex_valid),
        .ex_mem_reg     (ex_mem_reg),
        .mem_ready      (mem_ready),
        .dbus_addr      (dbus_addr),
        .dbus_wdata     (dbus_wdata),
        .dbus_byte_en   (dbus_byte_en),
        .dbus_ren       (dbus_ren),
        .dbus_wen       (dbus_wen),
        .dbus_busy      (dbus_busy),
        .dbus_rdata     (dbus_rdata),
        .brj_addr       (brj_addr),
        .pc4            (pc4),
        .redirect_brj   (redirect_brj),
        .redirect_pc4   (redirect_pc4),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_wen         (wb_wen),
        .wb_data        (wb_data),
        .misalign_fault (misalign_fault),
        .bus_timeout    (bus_timeout)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] data;
        logic        rbrj;
        logic        rpc4;
        logic [31:0] raddr;
        logic        fault;
        logic        tout;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_act, mon_exp;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic exp_t mk_exp(logic [4:0] rd, logic wen, logic [31:0] data, logic rbrj,
                                    logic rpc4, logic [31:0] raddr, logic fault, logic tout);
        exp_t e;
        e.rd = rd; e.wen = wen; e.data = data; e.rbrj = rbrj; e.rpc4 = rpc4;
        e.raddr = raddr; e.fault = fault; e.tout = tout;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (wb_valid) begin
            mon_act.rd    = wb_rd;
            mon_act.wen   = wb_wen;
            mon_act.data  = wb_data;
            mon_act.rbrj  = redirect_brj;
            mon_act.rpc4  = redirect_pc4;
            mon_act.raddr = redirect_brj ? brj_addr : (redirect_pc4 ? pc4 : 32'h0);
            mon_act.fault = misalign_fault;
            mon_act.tout  = bus_timeout;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no writeback",
                         wb_rd, wb_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_err++;
                    $display("FAIL wb_bundle: got rd=%0d wen=%b data=%h brj=%b pc4=%b raddr=%h flt=%b to=%b, expected rd=%0d wen=%b data=%h brj=%b pc4=%b raddr=%h flt=%b to=%b",
                             mon_act.rd, mon_act.wen, mon_act.data, mon_act.rbrj, mon_act.rpc4,
                             mon_act.raddr, mon_act.fault, mon_act.tout, mon_exp.rd, mon_exp.wen,
                             mon_exp.data, mon_exp.rbrj, mon_exp.rpc4, mon_exp.raddr,
                             mon_exp.fault, mon_exp.tout);
                end
            end
        end else if (redirect_brj || redirect_pc4 || misalign_fault || bus_timeout) begin
            n_vec++;
            n_err++;
            $display("FAIL stray_pulse: got brj=%b pc4=%b flt=%b to=%b, expected none",
                     redirect_brj, redirect_pc4, misalign_fault, bus_timeout);
        end
    end

    // Present a bundle and hold it until accepted; returns #1 after the accepting edge.
    task automatic issue(input ex_mem_t b);
        logic ok;
        ok = 1'b0;
        ex_valid   = 1'b1;
        ex_mem_reg = b;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge CLK);
            ok = mem_ready;
            @(posedge CLK);
            #1;
        end
        ex_valid = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: got mem_ready=0 for 50 cycles, expected acceptance");
        end
    endtask

    // Aligned memory access with nbusy wait cycles before completion.
    task automatic mem_op(input ex_mem_t b, input int nbusy, input word_t rdata,
                          input word_t exp_addr, input logic [3:0] exp_be,
                          input word_t exp_wdata);
        dbus_busy = (nbusy != 0);
        issue(b);
        for (int i = 0; i <= nbusy; i++) begin
            if (i == nbusy) begin
                dbus_busy  = 1'b0;
                dbus_rdata = rdata;
            end
            @(negedge CLK);
            chk("dbus_ren", dbus_ren, b.dren);
            chk("dbus_wen", dbus_wen, b.dwen);
            chk("mem_ready_access", mem_ready, i == nbusy);
            if (i == 0) begin
                chk("dbus_addr", dbus_addr, exp_addr);
                chk("dbus_byte_en", dbus_byte_en, exp_be);
                if (b.dwen) chk("dbus_wdata", dbus_wdata, exp_wdata);
            end
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        chk("req_dropped", {dbus_ren, dbus_wen}, 32'h0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: got no finish, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        ex_mem_t b;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("reset_mem_ready", mem_ready, 1'b1);
        chk("reset_ren_wen", {dbus_ren, dbus_wen}, 32'h0);
        chk("reset_wb_valid", wb_valid, 1'b0);
        chk("reset_wb_data", wb_data, 32'h0);
        chk("reset_redirects", {redirect_brj, redirect_pc4}, 32'h0);
        @(posedge CLK);
        #1;

        // ALU pass-through
        b = '0; b.alu_result = 32'h1234; b.rd = 5'd5; b.reg_wen = 1'b1;
        exp_q.push_back(mk_exp(5'd5, 1'b1, 32'h1234, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
        issue(b);
        @(negedge CLK);
        chk("alu_no_ren", dbus_ren, 1'b0);
        @(posedge CLK); #1;

        // LB signed, byte lane 3, three busy cycles
        b = '0; b.alu_result = 32'h103; b.dren = 1'b1; b.ld_st_type = LsB;
        b.rd = 5'd7; b.reg_wen = 1'b1;
        exp_q.push_back(mk_exp(5'd7, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
        mem_op(b, 3, 32'h80FFFFFF, 32'h100, 4'b1000, 32'h0);

        // LBU, same access
        b.ld_st_type = LsBu;
        exp_q.push_back(mk_exp(5'd7, 1'b1, 32'h00000080, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
        mem_op(b, 3, 32'h80FFFFFF, 32'h100, 4'b1000, 32'h0);

        // SH upper half
        b = '0; b.alu_result = 32'h202; b.dwen = 1'b1; b.ld_st_type = LsH;
        b.store_data = 32'h0000ABCD; b.rd = 5'd0;
        exp_q.push_back(mk_exp(5'd0, 1'b0, 32'h202, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
        mem_op(b, 0, 32'h0, 32'h200, 4'b1100, 32'hABCDABCD);

        // Misaligned LW: suppressed, fault pulse
        b = '0; b.alu_result = 32'h101; b.dren = 1'b1; b.ld_st_type = LsW;
        b.rd = 5'd3; b.reg_wen = 1'b1; b.brj_taken = 1'b1; b.brj_target = 32'h777;
        exp_q.push_back(mk_exp(5'd3, 1'b0, 32'h101, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0));
        issue(b);
        @(negedge CLK);
        chk("misalign_no_ren", dbus_ren, 1'b0);
        @(posedge CLK); #1;

        // JAL
        b = '0; b.pc = 32'h50; b.alu_result = 32'h54; b.rd = 5'd1; b.reg_wen = 1'b1;
        b.brj_taken = 1'b1; b.brj_target = 32'h400;
        exp_q.push_back(mk_exp(5'd1, 1'b1, 32'h54, 1'b1, 1'b0, 32'h400, 1'b0, 1'b0));
        issue(b);

        // fence.i at 0x80
        b = '0; b.pc = 32'h80; b.ifence = 1'b1;
        exp_q.push_back(mk_exp(5'd0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h84, 1'b0, 1'b0));
        issue(b);

        // CSR flush at top of address space wraps; rd=0 gates wen
        b = '0; b.pc = 32'hFFFFFFFC; b.csr_flush = 1'b1; b.reg_wen = 1'b1; b.alu_result = 32'h9;
        exp_q.push_back(mk_exp(5'd0, 1'b0, 32'h9, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0));
        issue(b);

        // Branch beats flush
        b = '0; b.pc = 32'h10; b.brj_taken = 1'b1; b.brj_target = 32'h500; b.ifence = 1'b1;
        exp_q.push_back(mk_exp(5'd0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 1'b0, 1'b0));
        issue(b);

        // Watchdog abort after 4 busy cycles
        b = '0; b.alu_result = 32'h300; b.dren = 1'b1; b.ld_st_type = LsW;
        b.rd = 5'd9; b.reg_wen = 1'b1;
        exp_q.push_back(mk_exp(5'd9, 1'b0, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1));
        dbus_busy = 1'b1;
        issue(b);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("timeout_ren_held", dbus_ren, 1'b1);
            chk("timeout_not_ready", mem_ready, 1'b0);
            @(posedge CLK); #1;
        end
        @(negedge CLK);
        chk("timeout_ren_drop", dbus_ren, 1'b0);
        chk("timeout_ready", mem_ready, 1'b1);
        @(posedge CLK); #1;
        dbus_busy = 1'b0;

        // Reset mid-access discards the instruction
        b = '0; b.alu_result = 32'h40; b.dren = 1'b1; b.ld_st_type = LsW;
        b.rd = 5'd4; b.reg_wen = 1'b1; b.brj_taken = 1'b1; b.brj_target = 32'h999;
        dbus_busy = 1'b1;
        issue(b);
        @(negedge CLK);
        chk("pre_reset_ren", dbus_ren, 1'b1);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        dbus_busy = 1'b0;
        @(negedge CLK);
        chk("rst_ren", dbus_ren, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_redirect", redirect_brj, 1'b0);
        chk("rst_ready", mem_ready, 1'b1);
        @(posedge CLK); #1;
        b.alu_result = 32'h44; b.brj_taken = 1'b0;
        exp_q.push_back(mk_exp(5'd4, 1'b1, 32'h11223344, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
        mem_op(b, 0, 32'h11223344, 32'h44, 4'b1111, 32'h0);

        // Back-to-back: signed LH upper half followed by an ALU op in the completion cycle
        b = '0; b.alu_result = 32'h102; b.dren = 1'b1; b.ld_st_type = LsH;
        b.rd = 5'd6; b.reg_wen = 1'b1;
        exp_q.push_back(mk_exp(5'd6, 1'b1, 32'hFFFFF00D, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
        exp_q.push_back(mk_exp(5'd8, 1'b1, 32'hCAFE, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
        dbus_busy  = 1'b0;
        dbus_rdata = 32'hF00D1234;
        issue(b);
        b = '0; b.alu_result = 32'hCAFE; b.rd = 5'd8; b.reg_wen = 1'b1;
        issue(b);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge CLK); #1;
        end
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        repeat (2) @(posedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
